pulse_shaper: RTL

- Output-side counterpart of the input debounce filter. The filter turns a noisy level into a clean one-cycle pulse; this block does the reverse.
- Converts one-cycle request pulses from internal logic into clean level pulses with guaranteed minimum high time and minimum low gap.
- Requests arriving while a pulse is in progress are queued in a saturating counter.
- Sits between control logic and slow external consumers (LED, buzzer, opto/relay driver) on the 100 MHz system clock.

---
 rtl/pulse_shaper_if.sv | 15 +
 rtl/pulse_shaper.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pulse_shaper_if.sv
// Request/level interface between control logic and the pulse shaper.
// The control side drives one-cycle requests; the shaper returns the shaped
// level plus queue status.
interface pulse_shaper_if #(
  parameter int PEND_W = 2
) ();
  logic              iPulse;
  logic              oSignal;
  logic              oBusy;
  logic [PEND_W-1:0] oPending;
  logic              oDrop;

  modport master (output iPulse, input oSignal, oBusy, oPending, oDrop);
  modport slave  (input iPulse, output oSignal, oBusy, oPending, oDrop);
endinterface

// File: rtl/pulse_shaper.sv
// Pulse shaper: turns one-cycle requests into level pulses of exactly
// HIGH_NUM cycles high followed by at least LOW_NUM cycles low. Requests that
// arrive while a pulse is in flight are queued in a saturating counter and
// replayed back to back, with no idle cycle between the low gap and the next
// high phase.
module pulse_shaper #(
  parameter int HIGH_NUM = 10,
  parameter int LOW_NUM  = 10,
  parameter int CNT_W    = 16,
  parameter int PEND_W   = 2
) (
  input  logic            CLK,
  input  logic            RST,
  pulse_shaper_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_NUM - 1);
  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_NUM - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [PEND_W-1:0]  pend;
  logic [PEND_W-1:0]  pend_nxt;
  logic               sig;
  logic               sig_nxt;
  logic               drop;
  logic               drop_nxt;
  logic               busy;
  logic               accept;
  logic               consume;

  // Saturating update of the queue depth. A consume only happens when the
  // effective count (pend + accept) is non-zero, so the decrement cannot wrap.
  // When full, an accept without a matching consume leaves the count alone.
  function automatic logic [PEND_W-1:0] pend_update(
    input logic [PEND_W-1:0] p,
    input logic              acc,
    input logic              con
  );
    logic [PEND_W-1:0] r;
    r = p;
    if (acc && !con) begin
      r = (p == PEND_MAX) ? p : p + 1'b1;
    end else if (!acc && con) begin
      r = p - 1'b1;
    end
    return r;
  endfunction

  // State register plus registered outputs; reset discards queued requests.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      sig   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      sig   <= sig_nxt;
      drop  <= drop_nxt;
    end
  end

  // Next-state and phase-counter logic, including the queue consume decision
  // at the end of the low gap (a same-cycle request counts as pending).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    consume   = 1'b0;
    accept    = bus.iPulse && (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.iPulse) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end
      end
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOW: begin
        if (cnt == LOW_LAST) begin
          cnt_nxt = '0;
          if ((pend != '0) || accept) begin
            consume   = 1'b1;
            state_nxt = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: next values for the registered outputs, busy from state.
  always_comb begin
    sig_nxt  = (state_nxt == HIGH);
    drop_nxt = accept && !consume && (pend == PEND_MAX);
    pend_nxt = pend_update(pend, accept, consume);
    busy     = (state != IDLE);
  end

  assign bus.oSignal  = sig;
  assign bus.oBusy    = busy;
  assign bus.oPending = pend;
  assign bus.oDrop    = drop;

endmodule
